// File: rtl/spwtcr_tx_scheduler.sv
// SpaceWire TX character scheduler: picks TIME / FCT / N-char / NULL for the encoder
// and owns the TX credit counter fed by received FCTs.
//  state | meaning
//  IDLE  | no character presented; selects the next one whenever txMode != OFF
//  BUSY  | charReq held with stable charType/charData until charAck
module spwtcr_tx_scheduler #(
    parameter int CREDIT_MAX = 56,
    parameter int FCT_STEP   = 8
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [1:0] txMode,
    input  logic       gotFCT,
    input  logic       sendFctReq,
    output logic       sendFctAck,
    input  logic       tickIn,
    input  logic [7:0] timeIn,
    input  logic       txDataValid,
    input  logic [8:0] txData,
    output logic       txDataRead,
    output logic       charReq,
    output logic [1:0] charType,
    output logic [8:0] charData,
    input  logic       charAck,
    output logic [6:0] txCredit,
    output logic       creditErr
);
    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_RUN = 2'b11;

    localparam logic [1:0] CT_NULL  = 2'b00;
    localparam logic [1:0] CT_FCT   = 2'b01;
    localparam logic [1:0] CT_TIME  = 2'b10;
    localparam logic [1:0] CT_NCHAR = 2'b11;

    localparam logic [7:0] CREDIT_LIMIT = 8'(CREDIT_MAX);
    localparam logic [7:0] CREDIT_INC   = 8'(FCT_STEP);

    typedef enum logic {IDLE, BUSY} stateType;

    stateType   state, nextState;
    logic       doSelect;
    logic [1:0] selType;
    logic [8:0] selData;
    logic       tickPend;
    logic [7:0] timeReg;
    logic       fctBlock;
    logic [7:0] creditSum;
    logic       creditOvf;
    logic [6:0] creditNext;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState  = state;
        doSelect   = 1'b0;
        selType    = CT_NULL;
        txDataRead = 1'b0;
        sendFctAck = 1'b0;
        if (txMode == MODE_OFF) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    doSelect  = 1'b1;
                    nextState = BUSY;
                    if (txMode == MODE_RUN && tickPend)
                        selType = CT_TIME;
                    else if (txMode[1] && sendFctReq && !fctBlock)
                        selType = CT_FCT;
                    else if (txMode == MODE_RUN && txDataValid && txCredit != '0) begin
                        selType    = CT_NCHAR;
                        txDataRead = 1'b1;
                    end
                end
                BUSY: begin
                    if (charAck) begin
                        nextState  = IDLE;
                        sendFctAck = (charType == CT_FCT);
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        selData = '0;
        if (selType == CT_NCHAR)     selData = txData;
        else if (selType == CT_TIME) selData = {1'b0, timeReg};
    end

    // An overflowing FCT leaves credit untouched, but a simultaneous N-char still consumes one.
    always_comb begin
        creditSum  = {1'b0, txCredit} + CREDIT_INC;
        creditOvf  = gotFCT && (creditSum > CREDIT_LIMIT);
        creditNext = txCredit;
        if (gotFCT && !creditOvf) creditNext = creditSum[6:0];
        if (txDataRead)           creditNext = creditNext - 7'd1;
    end

    assign charReq = (state == BUSY);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            charType  <= CT_NULL;
            charData  <= '0;
            txCredit  <= '0;
            creditErr <= 1'b0;
            tickPend  <= 1'b0;
            timeReg   <= '0;
            fctBlock  <= 1'b0;
        end else begin
            fctBlock <= sendFctAck;
            if (doSelect) begin
                charType <= selType;
                charData <= selData;
            end
            if (txMode == MODE_OFF) begin
                txCredit  <= '0;
                creditErr <= 1'b0;
                tickPend  <= 1'b0;
            end else begin
                txCredit <= creditNext;
                if (creditOvf) creditErr <= 1'b1;
                // A tick arriving as the previous time-code issues stays pending.
                if (tickIn && txMode == MODE_RUN) begin
                    tickPend <= 1'b1;
                    timeReg  <= timeIn;
                end else if (doSelect && selType == CT_TIME) begin
                    tickPend <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_spwtcr_tx_scheduler.sv
// Bench for spwtcr_tx_scheduler: directed scenarios plus random traffic, every cycle
// compared against a character-level reference model of the scheduler rules.
module tb_spwtcr_tx_scheduler;
    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [1:0] txMode;
    logic       gotFCT, sendFctReq, sendFctAck, tickIn;
    logic [7:0] timeIn;
    logic       txDataValid;
    logic [8:0] txData;
    logic       txDataRead, charReq;
    logic [1:0] charType;
    logic [8:0] charData;
    logic       charAck;
    logic [6:0] txCredit;
    logic       creditErr;

    spwtcr_tx_scheduler dut (
        .CLOCK(CLOCK), .RESET(RESET), .txMode(txMode), .gotFCT(gotFCT),
        .sendFctReq(sendFctReq), .sendFctAck(sendFctAck), .tickIn(tickIn), .timeIn(timeIn),
        .txDataValid(txDataValid), .txData(txData), .txDataRead(txDataRead),
        .charReq(charReq), .charType(charType), .charData(charData), .charAck(charAck),
        .txCredit(txCredit), .creditErr(creditErr)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // reference model: the character on offer and the link bookkeeping
    bit mBusy, mErr, mPend, mBlock;
    int mType, mData, mCredit, mTime;
    int busyAge;
    bit autoAck, prevReq, logOn;
    int logType[$];
    int logData[$];
    int popCnt, ackCnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // priority rule: 2 TIME, 1 FCT, 3 NCHAR, 0 NULL, -1 nothing (link off)
    function automatic int pick();
        if (txMode == 2'd0) return -1;
        if (txMode == 2'd3 && mPend) return 2;
        if (txMode >= 2'd2 && sendFctReq && !mBlock) return 1;
        if (txMode == 2'd3 && txDataValid && mCredit > 0) return 3;
        return 0;
    endfunction

    task automatic step();
        int sel;
        bit expRead, expAck, newBlock, wasBusy;
        int dec;
        if (autoAck) charAck = mBusy && busyAge >= 1;
        #1;
        sel     = pick();
        expRead = !mBusy && sel == 3;
        expAck  = txMode != 2'd0 && mBusy && charAck && mType == 1;
        chk("charReq", charReq, mBusy);
        chk("txCredit", txCredit, mCredit);
        chk("creditErr", creditErr, mErr);
        chk("txDataRead", txDataRead, expRead);
        chk("sendFctAck", sendFctAck, expAck);
        if (mBusy) begin
            chk("charType", charType, mType);
            chk("charData", charData, mData);
        end
        if (txDataRead) popCnt++;
        if (sendFctAck) ackCnt++;
        if (logOn && charReq && !prevReq) begin
            logType.push_back(int'(charType));
            logData.push_back(int'(charData));
        end
        prevReq  = charReq;
        wasBusy  = mBusy;
        dec      = 0;
        newBlock = expAck;
        if (txMode == 2'd0) begin
            mBusy = 0; mCredit = 0; mErr = 0; mPend = 0; mBlock = 0;
        end else begin
            if (!mBusy) begin
                mBusy = 1;
                mType = sel;
                mData = (sel == 3) ? int'(txData) : (sel == 2) ? mTime : 0;
                if (sel == 2) mPend = 0;
                if (sel == 3) dec = 1;
            end else if (charAck) begin
                mBusy = 0;
            end
            if (gotFCT) begin
                if (mCredit + 8 > 56) mErr = 1;
                else                  mCredit += 8;
            end
            mCredit -= dec;
            if (tickIn && txMode == 2'd3) begin
                mPend = 1;
                mTime = int'(timeIn);
            end
            mBlock = newBlock;
        end
        busyAge = (mBusy && wasBusy) ? busyAge + 1 : 0;
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    initial begin
        int nonNull;
        int popBefore;
        RESET = 1'b1; txMode = 2'd0; gotFCT = 0; sendFctReq = 0; tickIn = 0; timeIn = '0;
        txDataValid = 0; txData = '0; charAck = 0;
        mBusy = 0; mErr = 0; mPend = 0; mBlock = 0; mType = 0; mData = 0; mCredit = 0; mTime = 0;
        busyAge = 0; autoAck = 1; prevReq = 0; logOn = 0; popCnt = 0; ackCnt = 0;

        repeat (3) @(negedge CLOCK);
        chk("rstReq", charReq, 0);
        chk("rstType", charType, 0);
        chk("rstData", charData, 0);
        chk("rstCredit", txCredit, 0);
        chk("rstErr", creditErr, 0);
        chk("rstRead", txDataRead, 0);
        chk("rstAck", sendFctAck, 0);
        RESET = 1'b0;
        step();

        // NULL-only mode: endless NULLs, FIFO never popped
        txMode = 2'd1; txDataValid = 1; logOn = 1; popCnt = 0;
        repeat (20) step();
        nonNull = 0;
        foreach (logType[i]) if (logType[i] != 0) nonNull++;
        chk("m1Pops", popCnt, 0);
        chk("m1NonNull", nonNull, 0);
        chk("m1Enough", logType.size() >= 5, 1);

        // NULL+FCT mode: one FCT with one ack pulse, then NULL
        logType.delete(); logData.delete();
        txMode = 2'd2; sendFctReq = 1; ackCnt = 0;
        repeat (20) begin
            step();
            if (ackCnt > 0) sendFctReq = 0;
        end
        chk("m2Acks", ackCnt, 1);
        chk("m2First", logType.size() > 0 ? logType[0] : -1, 1);
        chk("m2Second", logType.size() > 1 ? logType[1] : -1, 0);
        chk("m2Credit", txCredit, 0);

        // credit fill to 56, overflow on the 8th FCT, cleared by OFF
        logOn = 0; txDataValid = 0; txMode = 2'd0; step();
        txMode = 2'd3;
        repeat (7) begin
            gotFCT = 1; step();
            gotFCT = 0; step();
        end
        chk("fillCredit", txCredit, 56);
        chk("fillErr", creditErr, 0);
        gotFCT = 1; step(); gotFCT = 0; step();
        chk("ovfCredit", txCredit, 56);
        chk("ovfErr", creditErr, 1);
        txMode = 2'd0; step();
        chk("offCredit", txCredit, 0);
        chk("offErr", creditErr, 0);

        // 8 credits against a longer FIFO: exactly 8 N-chars
        txMode = 2'd3; gotFCT = 1; step(); gotFCT = 0;
        popCnt = 0; txDataValid = 1;
        repeat (40) begin
            txData = 9'($urandom);
            step();
        end
        chk("nchPops", popCnt, 8);
        chk("nchCredit", txCredit, 0);
        txDataValid = 0; gotFCT = 1; step(); gotFCT = 0;
        for (int i = 0; i < 10 && mBusy; i++) step();
        txDataValid = 1; txData = 9'h0A5; gotFCT = 1; step();
        gotFCT = 0;
        chk("fctPlusNchar", txCredit, 15);

        // two ticks while BUSY on an N-char, FCT wanted: TIME(0x2A), FCT, NCHAR
        autoAck = 0; charAck = 0;
        for (int i = 0; i < 10 && !(mBusy && mType == 3); i++) step();
        tickIn = 1; timeIn = 8'h15; step();
        timeIn = 8'h2A; step();
        tickIn = 0; sendFctReq = 1;
        logType.delete(); logData.delete(); logOn = 1; autoAck = 1; ackCnt = 0;
        for (int i = 0; i < 30 && logType.size() < 3; i++) begin
            step();
            if (ackCnt > 0) sendFctReq = 0;
        end
        chk("seqLen", logType.size(), 3);
        chk("seqTime", logType.size() > 0 ? logType[0] : -1, 2);
        chk("seqTimeVal", logData.size() > 0 ? logData[0] : -1, 32'h2A);
        chk("seqFct", logType.size() > 1 ? logType[1] : -1, 1);
        chk("seqNchar", logType.size() > 2 ? logType[2] : -1, 3);
        logOn = 0; sendFctReq = 0;

        // link drops to OFF mid-character; a late ack is ignored
        autoAck = 0; charAck = 0;
        for (int i = 0; i < 10 && !(mBusy && mType == 3); i++) step();
        popBefore = popCnt;
        txMode = 2'd0; step();
        chk("abortReq", charReq, 0);
        chk("abortCredit", txCredit, 0);
        charAck = 1; step();
        charAck = 0;
        chk("lateAckReq", charReq, 0);
        chk("lateAckPops", popCnt, popBefore);

        // random traffic against the model
        txMode = 2'd3;
        repeat (2000) begin
            if ($urandom_range(0, 49) == 0) txMode = 2'($urandom_range(0, 3));
            gotFCT      = ($urandom_range(0, 15) == 0);
            tickIn      = ($urandom_range(0, 15) == 0);
            timeIn      = 8'($urandom);
            sendFctReq  = ($urandom_range(0, 3) == 0) ? ~sendFctReq : sendFctReq;
            txDataValid = ($urandom_range(0, 3) != 0);
            txData      = 9'($urandom);
            charAck     = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
